// File: rtl/ddr3_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_arb_pkg
// Shared types and constants for the DDR3 user-port arbiter.
//   arb_state_t : arbiter FSM states (also exported on the debug port)
//   AXI_LEN_W   : width of the AXI burst length field (beats = len+1)
//   MAX_PORTS   : largest supported number of requesters
//   PORT_IDX_W  : width of a requester index, sized for MAX_PORTS
// ---------------------------------------------------------------------------
package ddr3_arb_pkg;

  localparam int AXI_LEN_W  = 4;
  localparam int MAX_PORTS  = 4;
  localparam int PORT_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AW    = 3'd1,
    ST_WDATA = 3'd2,
    ST_AR    = 3'd3,
    ST_RDATA = 3'd4
  } arb_state_t;

endpackage

// File: rtl/ddr3_axi_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at the port
// after i_last_grant and wraps, so the most recent winner has the lowest
// priority. The last-grant register is owned by the parent.
//   i_req        : per-port request bits
//   i_last_grant : index of the previous winner
//   o_gnt        : one-hot winner (0 when nobody requests)
//   o_gnt_idx    : index of the winner
//   o_any        : at least one port requests
// ---------------------------------------------------------------------------
module rr_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]  i_req,
  input  logic [PORT_IDX_W-1:0] i_last_grant,
  output logic [NUM_PORTS-1:0]  o_gnt,
  output logic [PORT_IDX_W-1:0] o_gnt_idx,
  output logic                  o_any
);

  // Outer loop walks the priority order (offset 1..N from the last winner);
  // the inner loop keeps every bit-select a constant after unrolling.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!o_any && i_req[j] &&
            (((int'(i_last_grant) + i) % NUM_PORTS) == j)) begin
          o_gnt[j]  = 1'b1;
          o_gnt_idx = PORT_IDX_W'(j);
          o_any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr3_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_axi_arbiter
// Shares the single ID-less AXI user port of the DDR3 controller between
// NUM_PORTS requesters. One burst is in flight at a time: a command is
// granted round-robin, driven on AW or AR, and the write-data pull or read
// return is routed to the owner until the last beat.
//
// Handshake rules: a requester holds i_req (and its fields) until it sees its
// o_req_ack pulse, which is combinational with the AW/AR valid&&ready cycle.
// awvalid/arvalid are registered, rise one cycle after a grant and drop only
// the cycle after their handshake. wready/rvalid/rlast/wusero_last are routed
// combinationally to the owner; non-owners see 0.
//
// Ports:
//   core_clk, ddr_rst          : clock, async active-high reset
//   ddrc_init_done             : grants are held off while low
//   i_req/i_req_wr/addr/len    : per-port command request
//   o_req_ack                  : per-port command accepted pulse
//   i_wr_data, o_wr_ready/last : per-port write data pull
//   o_rd_data, o_rd_valid/last : read return (data broadcast, valid routed)
//   o_grant                    : one-hot owner, 0 when idle
//   o_len_err                  : sticky beat-count mismatch flag
//   o_m_axi_* / i_m_axi_*      : controller user port (AW, W, AR, R)
//   o_dbg_state                : current FSM state
// ---------------------------------------------------------------------------
module ddr3_axi_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int NUM_PORTS       = 2
) (
  input  logic                                     core_clk,
  input  logic                                     ddr_rst,
  input  logic                                     ddrc_init_done,

  input  logic [NUM_PORTS-1:0]                     i_req,
  input  logic [NUM_PORTS-1:0]                     i_req_wr,
  input  logic [NUM_PORTS*CTRL_ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [NUM_PORTS*AXI_LEN_W-1:0]           i_req_len,
  output logic [NUM_PORTS-1:0]                     o_req_ack,

  input  logic [NUM_PORTS*MEM_DQ_WIDTH*8-1:0]      i_wr_data,
  output logic [NUM_PORTS-1:0]                     o_wr_ready,
  output logic [NUM_PORTS-1:0]                     o_wr_last,

  output logic [MEM_DQ_WIDTH*8-1:0]                o_rd_data,
  output logic [NUM_PORTS-1:0]                     o_rd_valid,
  output logic [NUM_PORTS-1:0]                     o_rd_last,

  output logic [NUM_PORTS-1:0]                     o_grant,
  output logic                                     o_len_err,

  output logic [CTRL_ADDR_WIDTH-1:0]               o_m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]                     o_m_axi_awlen,
  output logic                                     o_m_axi_awvalid,
  input  logic                                     i_m_axi_awready,

  output logic [MEM_DQ_WIDTH*8-1:0]                o_m_axi_wdata,
  input  logic                                     i_m_axi_wready,
  input  logic                                     i_m_axi_wusero_last,

  output logic [CTRL_ADDR_WIDTH-1:0]               o_m_axi_araddr,
  output logic [AXI_LEN_W-1:0]                     o_m_axi_arlen,
  output logic                                     o_m_axi_arvalid,
  input  logic                                     i_m_axi_arready,

  input  logic [MEM_DQ_WIDTH*8-1:0]                i_m_axi_rdata,
  input  logic                                     i_m_axi_rlast,
  input  logic                                     i_m_axi_rvalid,

  output logic [2:0]                               o_dbg_state
);

  localparam int DW = MEM_DQ_WIDTH * 8;
  localparam int AW = CTRL_ADDR_WIDTH;

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [NUM_PORTS-1:0]    r_gnt;
  logic [PORT_IDX_W-1:0]   r_gidx;
  logic [PORT_IDX_W-1:0]   r_last_grant;
  logic [AW-1:0]           r_addr;
  logic [AXI_LEN_W-1:0]    r_len;
  logic [AXI_LEN_W:0]      r_cnt;        // beat counter with carry bit
  logic                    r_last_seen;  // last beat already arrived during AW/AR
  logic                    r_len_err;

  logic [NUM_PORTS-1:0]    w_arb_gnt;
  logic [PORT_IDX_W-1:0]   w_arb_idx;
  logic                    w_arb_any;

  logic                    w_sel_wr;
  logic [AW-1:0]           w_sel_addr;
  logic [AXI_LEN_W-1:0]    w_sel_len;

  logic                    w_wphase;
  logic                    w_rphase;
  logic                    w_aw_hs;
  logic                    w_ar_hs;
  logic                    w_wbeat;
  logic                    w_rbeat;
  logic                    w_last_evt;
  logic                    w_grant_fire;
  logic [AXI_LEN_W:0]      w_cnt_inc;
  logic [AXI_LEN_W:0]      w_len_beats;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .i_req        (i_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_arb_gnt),
    .o_gnt_idx    (w_arb_idx),
    .o_any        (w_arb_any)
  );

  // Command fields of the arbitration winner.
  always_comb begin
    w_sel_wr   = 1'b0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_arb_gnt[p]) begin
        w_sel_wr   = i_req_wr[p];
        w_sel_addr = i_req_addr[p*AW +: AW];
        w_sel_len  = i_req_len[p*AXI_LEN_W +: AXI_LEN_W];
      end
    end
  end

  // Write data may arrive while AW is still pending, read data while AR is
  // pending, so the data phases include the address states.
  assign w_wphase     = (r_state == ST_AW) || (r_state == ST_WDATA);
  assign w_rphase     = (r_state == ST_AR) || (r_state == ST_RDATA);
  assign w_aw_hs      = (r_state == ST_AW) && i_m_axi_awready;
  assign w_ar_hs      = (r_state == ST_AR) && i_m_axi_arready;
  assign w_wbeat      = w_wphase && i_m_axi_wready;
  assign w_rbeat      = w_rphase && i_m_axi_rvalid;
  assign w_last_evt   = !r_last_seen &&
                        ((w_wphase && i_m_axi_wusero_last) ||
                         (w_rbeat && i_m_axi_rlast));
  assign w_grant_fire = (r_state == ST_IDLE) && ddrc_init_done && w_arb_any;

  // Beats seen including the current last beat, versus len+1.
  assign w_cnt_inc    = r_cnt + 5'd1;
  assign w_len_beats  = {1'b0, r_len} + 5'd1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_fire) w_state_nxt = w_sel_wr ? ST_AW : ST_AR;
      end
      ST_AW: begin
        if (w_aw_hs) w_state_nxt = (r_last_seen || w_last_evt) ? ST_IDLE : ST_WDATA;
      end
      ST_WDATA: begin
        if (i_m_axi_wusero_last) w_state_nxt = ST_IDLE;
      end
      ST_AR: begin
        if (w_ar_hs) w_state_nxt = (r_last_seen || w_last_evt) ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: begin
        if (w_rbeat && i_m_axi_rlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_gidx       <= '0;
      r_last_grant <= PORT_IDX_W'(NUM_PORTS - 1);
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_last_seen  <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_fire) begin
        r_gnt        <= w_arb_gnt;
        r_gidx       <= w_arb_idx;
        r_last_grant <= w_arb_idx;
        r_addr       <= w_sel_addr;
        r_len        <= w_sel_len;
        r_cnt        <= '0;
        r_last_seen  <= 1'b0;
      end else begin
        if (w_state_nxt == ST_IDLE) r_gnt <= '0;
        // Saturate at the carry so a runaway burst cannot wrap back to a match.
        if ((w_wbeat || w_rbeat) && !r_cnt[AXI_LEN_W]) r_cnt <= w_cnt_inc;
        if (w_last_evt) r_last_seen <= 1'b1;
      end
      if (w_last_evt && (w_cnt_inc != w_len_beats)) r_len_err <= 1'b1;
    end
  end

  // Routing to the owner; everything is forced to 0 outside its phase.
  always_comb begin
    o_req_ack     = (w_aw_hs || w_ar_hs) ? r_gnt : '0;
    o_wr_ready    = w_wbeat ? r_gnt : '0;
    o_wr_last     = (w_wphase && i_m_axi_wusero_last) ? r_gnt : '0;
    o_rd_valid    = w_rbeat ? r_gnt : '0;
    o_rd_last     = (w_rphase && i_m_axi_rlast) ? r_gnt : '0;
    o_rd_data     = w_rphase ? i_m_axi_rdata : '0;
    o_m_axi_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_wphase && (r_gidx == PORT_IDX_W'(p))) o_m_axi_wdata = i_wr_data[p*DW +: DW];
    end
  end

  assign o_grant         = r_gnt;
  assign o_len_err       = r_len_err;
  assign o_m_axi_awaddr  = r_addr;
  assign o_m_axi_awlen   = r_len;
  assign o_m_axi_awvalid = (r_state == ST_AW);
  assign o_m_axi_araddr  = r_addr;
  assign o_m_axi_arlen   = r_len;
  assign o_m_axi_arvalid = (r_state == ST_AR);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_ddr3_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr3_axi_arbiter
// Bench for ddr3_axi_arbiter with two requesters and a small IP model.
// Inputs are driven 1 ns after the rising edge, outputs sampled 2 ns after.
// ---------------------------------------------------------------------------
module tb_ddr3_axi_arbiter;
  import ddr3_arb_pkg::*;

  localparam int AW = 28;
  localparam int DQ = 16;
  localparam int NP = 2;
  localparam int DW = DQ * 8;

  logic                 core_clk = 1'b0;
  logic                 ddr_rst;
  logic                 ddrc_init_done;
  logic [NP-1:0]        i_req;
  logic [NP-1:0]        i_req_wr;
  logic [NP*AW-1:0]     i_req_addr;
  logic [NP*4-1:0]      i_req_len;
  logic [NP-1:0]        o_req_ack;
  logic [NP*DW-1:0]     i_wr_data;
  logic [NP-1:0]        o_wr_ready;
  logic [NP-1:0]        o_wr_last;
  logic [DW-1:0]        o_rd_data;
  logic [NP-1:0]        o_rd_valid;
  logic [NP-1:0]        o_rd_last;
  logic [NP-1:0]        o_grant;
  logic                 o_len_err;
  logic [AW-1:0]        o_m_axi_awaddr;
  logic [3:0]           o_m_axi_awlen;
  logic                 o_m_axi_awvalid;
  logic                 i_m_axi_awready;
  logic [DW-1:0]        o_m_axi_wdata;
  logic                 i_m_axi_wready;
  logic                 i_m_axi_wusero_last;
  logic [AW-1:0]        o_m_axi_araddr;
  logic [3:0]           o_m_axi_arlen;
  logic                 o_m_axi_arvalid;
  logic                 i_m_axi_arready;
  logic [DW-1:0]        i_m_axi_rdata;
  logic                 i_m_axi_rlast;
  logic                 i_m_axi_rvalid;
  logic [2:0]           o_dbg_state;

  ddr3_axi_arbiter #(
    .CTRL_ADDR_WIDTH (AW),
    .MEM_DQ_WIDTH    (DQ),
    .NUM_PORTS       (NP)
  ) dut (
    .core_clk            (core_clk),
    .ddr_rst             (ddr_rst),
    .ddrc_init_done      (ddrc_init_done),
    .i_req               (i_req),
    .i_req_wr            (i_req_wr),
    .i_req_addr          (i_req_addr),
    .i_req_len           (i_req_len),
    .o_req_ack           (o_req_ack),
    .i_wr_data           (i_wr_data),
    .o_wr_ready          (o_wr_ready),
    .o_wr_last           (o_wr_last),
    .o_rd_data           (o_rd_data),
    .o_rd_valid          (o_rd_valid),
    .o_rd_last           (o_rd_last),
    .o_grant             (o_grant),
    .o_len_err           (o_len_err),
    .o_m_axi_awaddr      (o_m_axi_awaddr),
    .o_m_axi_awlen       (o_m_axi_awlen),
    .o_m_axi_awvalid     (o_m_axi_awvalid),
    .i_m_axi_awready     (i_m_axi_awready),
    .o_m_axi_wdata       (o_m_axi_wdata),
    .i_m_axi_wready      (i_m_axi_wready),
    .i_m_axi_wusero_last (i_m_axi_wusero_last),
    .o_m_axi_araddr      (o_m_axi_araddr),
    .o_m_axi_arlen       (o_m_axi_arlen),
    .o_m_axi_arvalid     (o_m_axi_arvalid),
    .i_m_axi_arready     (i_m_axi_arready),
    .i_m_axi_rdata       (i_m_axi_rdata),
    .i_m_axi_rlast       (i_m_axi_rlast),
    .i_m_axi_rvalid      (i_m_axi_rvalid),
    .o_dbg_state         (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 core_clk = ~core_clk;

  // ---------------- bench state ----------------
  typedef struct {
    bit             wr;
    int             port;
    logic [AW-1:0]  addr;
    logic [3:0]     len;
  } cmd_t;

  cmd_t           port_q0[$];
  cmd_t           port_q1[$];
  cmd_t           exp_cmd_q[$];
  logic [DW-1:0]  exp_wq[$];
  logic [DW-1:0]  exp_rq[$];
  int             exp_rport_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  bit            aw_block;
  int            rlast_override;
  int            ip_w_port, ip_w_total, ip_w_beat;
  int            ip_r_total, ip_r_beat;
  logic [AW-1:0] ip_r_addr;
  int            wbeat[NP];
  int            n_wrr[NP];
  int            n_rdv[NP];

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] oh(input int p);
    return NP'(1) << p;
  endfunction

  function automatic logic [DW-1:0] wpat(input int p, input int b);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(p) * 32'h0001_0000 + 32'(b);
    return {(DW/32){w}};
  endfunction

  function automatic logic [DW-1:0] rpat(input logic [AW-1:0] a, input int b);
    logic [31:0] w;
    w = 32'h5A00_0000 ^ (32'(a) + 32'(b) * 32'h10);
    return {w, ~w, w ^ 32'(b), 32'(b)};
  endfunction

  // ---------------- driver tasks ----------------
  function automatic int pq_size(input int p);
    return (p == 0) ? port_q0.size() : port_q1.size();
  endfunction

  function automatic cmd_t pq_head(input int p);
    return (p == 0) ? port_q0[0] : port_q1[0];
  endfunction

  task automatic add_cmd(input bit wr, input int p, input logic [AW-1:0] a, input logic [3:0] l);
    cmd_t c;
    c.wr = wr; c.port = p; c.addr = a; c.len = l;
    if (p == 0) port_q0.push_back(c);
    else        port_q1.push_back(c);
  endtask

  // Expected grant order; write data expectations follow the same order.
  task automatic exp_cmd(input bit wr, input int p, input logic [AW-1:0] a, input logic [3:0] l);
    cmd_t c;
    c.wr = wr; c.port = p; c.addr = a; c.len = l;
    exp_cmd_q.push_back(c);
    if (wr) for (int b = 0; b <= int'(l); b++) exp_wq.push_back(wpat(p, b));
  endtask

  task automatic both(input bit wr, input int p, input logic [AW-1:0] a, input logic [3:0] l);
    add_cmd(wr, p, a, l);
    exp_cmd(wr, p, a, l);
  endtask

  // One clock: drive requesters and IP model, then sample and score.
  task automatic step();
    cmd_t c;
    int   rp;
    @(posedge core_clk);
    #1;
    i_req = '0;
    for (int p = 0; p < NP; p++) begin
      if (pq_size(p) > 0) begin
        c = pq_head(p);
        i_req[p]            = 1'b1;
        i_req_wr[p]         = c.wr;
        i_req_addr[p*AW +: AW] = c.addr;
        i_req_len[p*4 +: 4] = c.len;
      end
      i_wr_data[p*DW +: DW] = wpat(p, wbeat[p]);
    end
    i_m_axi_awready     = !aw_block && ($urandom_range(0, 1) == 1);
    i_m_axi_arready     = ($urandom_range(0, 1) == 1);
    i_m_axi_wready      = (ip_w_beat < ip_w_total) && ($urandom_range(0, 3) != 0);
    i_m_axi_wusero_last = i_m_axi_wready && (ip_w_beat == ip_w_total - 1);
    i_m_axi_rvalid      = (ip_r_beat < ip_r_total) && ($urandom_range(0, 3) != 0);
    i_m_axi_rlast       = i_m_axi_rvalid && (ip_r_beat == ip_r_total - 1);
    i_m_axi_rdata       = i_m_axi_rvalid ? rpat(ip_r_addr, ip_r_beat)
                                         : {$urandom, $urandom, $urandom, $urandom};
    #1;
    if (o_grant != '0) chk("grant_onehot", 128'($onehot(o_grant)), 128'd1);

    if ((o_m_axi_awvalid && i_m_axi_awready) || (o_m_axi_arvalid && i_m_axi_arready)) begin
      chk("serialised", 128'((ip_w_total != 0) || (ip_r_total != 0)), 128'd0);
      if (exp_cmd_q.size() == 0) begin
        chk("unexpected_cmd", 128'd1, 128'd0);
      end else begin
        c = exp_cmd_q.pop_front();
        chk("ack", o_req_ack, oh(c.port));
        chk("grant", o_grant, oh(c.port));
        chk("cmd_dir", o_m_axi_awvalid, c.wr);
        if (c.wr) begin
          chk("awaddr", o_m_axi_awaddr, c.addr);
          chk("awlen", o_m_axi_awlen, c.len);
          ip_w_total = int'(c.len) + 1;
          ip_w_beat  = 0;
          ip_w_port  = c.port;
        end else begin
          chk("araddr", o_m_axi_araddr, c.addr);
          chk("arlen", o_m_axi_arlen, c.len);
          ip_r_total = (rlast_override > 0) ? rlast_override : int'(c.len) + 1;
          ip_r_beat  = 0;
          ip_r_addr  = c.addr;
          for (int b = 0; b < ip_r_total; b++) begin
            exp_rq.push_back(rpat(c.addr, b));
            exp_rport_q.push_back(c.port);
          end
        end
      end
    end

    // Requester side reacts to its own ack and ready pulses.
    for (int p = 0; p < NP; p++) begin
      if (o_req_ack[p]) begin
        if (p == 0) void'(port_q0.pop_front());
        else        void'(port_q1.pop_front());
        wbeat[p] = 0;
      end
      if (o_wr_ready[p]) begin
        wbeat[p]++;
        n_wrr[p]++;
      end
      if (o_rd_valid[p]) n_rdv[p]++;
    end

    if (i_m_axi_wready) begin
      chk("wr_ready_route", o_wr_ready, oh(ip_w_port));
      if (exp_wq.size() == 0) chk("wq_underflow", 128'd1, 128'd0);
      else                    chk("wdata", o_m_axi_wdata, exp_wq.pop_front());
      if (i_m_axi_wusero_last) chk("wr_last", o_wr_last, oh(ip_w_port));
      ip_w_beat++;
      if (ip_w_beat == ip_w_total) begin
        ip_w_total = 0;
        ip_w_beat  = 0;
      end
    end

    if (i_m_axi_rvalid) begin
      if (exp_rq.size() == 0) begin
        chk("rq_underflow", 128'd1, 128'd0);
      end else begin
        rp = exp_rport_q.pop_front();
        chk("rd_valid_route", o_rd_valid, oh(rp));
        chk("rdata", o_rd_data, exp_rq.pop_front());
        if (i_m_axi_rlast) chk("rd_last", o_rd_last, oh(rp));
      end
      ip_r_beat++;
      if (ip_r_beat == ip_r_total) begin
        ip_r_total = 0;
        ip_r_beat  = 0;
      end
    end
  endtask

  function automatic bit all_idle();
    return (port_q0.size() == 0) && (port_q1.size() == 0) && (exp_cmd_q.size() == 0) &&
           (ip_w_total == 0) && (ip_r_total == 0) && (o_grant == '0);
  endfunction

  task automatic run_done(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!all_idle() && (n < budget));
    chk({tag, "_finished"}, 128'(all_idle()), 128'd1);
    chk({tag, "_wq_drained"}, 128'(exp_wq.size()), 128'd0);
    chk({tag, "_rq_drained"}, 128'(exp_rq.size()), 128'd0);
  endtask

  task automatic clear_counts();
    for (int p = 0; p < NP; p++) begin
      n_wrr[p] = 0;
      n_rdv[p] = 0;
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, {o_req_ack, o_wr_ready, o_wr_last, o_rd_valid, o_rd_last, o_grant,
                        o_len_err, o_m_axi_awaddr, o_m_axi_awlen, o_m_axi_awvalid,
                        o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arvalid, o_dbg_state}, 128'd0);
    chk({tag, "_rdata"}, o_rd_data, 128'd0);
    chk({tag, "_wdata"}, o_m_axi_wdata, 128'd0);
  endtask

  task automatic idle_inputs();
    i_req = '0; i_req_wr = '0; i_req_addr = '0; i_req_len = '0; i_wr_data = '0;
    i_m_axi_awready = 1'b0; i_m_axi_arready = 1'b0; i_m_axi_wready = 1'b0;
    i_m_axi_wusero_last = 1'b0; i_m_axi_rvalid = 1'b0; i_m_axi_rlast = 1'b0;
    i_m_axi_rdata = '0;
  endtask

  task automatic clear_model();
    port_q0.delete(); port_q1.delete(); exp_cmd_q.delete();
    exp_wq.delete(); exp_rq.delete(); exp_rport_q.delete();
    ip_w_total = 0; ip_w_beat = 0; ip_w_port = 0;
    ip_r_total = 0; ip_r_beat = 0; ip_r_addr = '0;
    for (int p = 0; p < NP; p++) wbeat[p] = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int vcnt;
    int n;
    ddr_rst        = 1'b1;
    ddrc_init_done = 1'b0;
    aw_block       = 1'b0;
    rlast_override = 0;
    idle_inputs();
    clear_model();
    clear_counts();
    repeat (3) @(posedge core_clk);
    #1 ddr_rst = 1'b0;
    #1 chk_outs_zero("reset");

    // Init gate, then a single 16-beat write from port 0.
    both(1'b1, 0, 28'h100, 4'd15);
    aw_block = 1'b1;
    vcnt = 0;
    repeat (100) begin
      step();
      if (o_m_axi_awvalid || o_m_axi_arvalid) vcnt++;
    end
    chk("gate_no_valid", 128'(vcnt), 128'd0);
    ddrc_init_done = 1'b1;
    step();
    chk("gate_awvalid", o_m_axi_awvalid, 128'd1);
    chk("gate_grant", o_grant, 128'b01);
    chk("gate_state", o_dbg_state, 128'(ST_AW));
    aw_block = 1'b0;
    clear_counts();
    run_done(400, "wr1");
    chk("wr1_beats", 128'(n_wrr[0]), 128'd16);
    chk("wr1_len_err", o_len_err, 128'd0);

    // Short read on port 1.
    both(1'b0, 1, 28'h2000, 4'd3);
    run_done(200, "rd1");

    // Mixed: write on port 0 and read on port 1 in the same cycle.
    add_cmd(1'b1, 0, 28'h300, 4'd7);
    add_cmd(1'b0, 1, 28'h400, 4'd7);
    exp_cmd(1'b1, 0, 28'h300, 4'd7);
    exp_cmd(1'b0, 1, 28'h400, 4'd7);
    run_done(400, "mixed");

    // Round-robin with both ports requesting reads back to back.
    add_cmd(1'b0, 0, 28'h1000, 4'd15);
    add_cmd(1'b0, 0, 28'h1100, 4'd15);
    add_cmd(1'b0, 1, 28'h2000, 4'd15);
    add_cmd(1'b0, 1, 28'h2100, 4'd15);
    exp_cmd(1'b0, 0, 28'h1000, 4'd15);
    exp_cmd(1'b0, 1, 28'h2000, 4'd15);
    exp_cmd(1'b0, 0, 28'h1100, 4'd15);
    exp_cmd(1'b0, 1, 28'h2100, 4'd15);
    clear_counts();
    run_done(1000, "rr");
    chk("rr_beats_p0", 128'(n_rdv[0]), 128'd32);
    chk("rr_beats_p1", 128'(n_rdv[1]), 128'd32);
    chk("rr_len_err", o_len_err, 128'd0);

    // Length error: rlast on beat 8 of a 16-beat read, then sticky.
    rlast_override = 8;
    both(1'b0, 0, 28'h800, 4'd15);
    run_done(300, "lenerr");
    rlast_override = 0;
    chk("len_err_set", o_len_err, 128'd1);
    both(1'b0, 1, 28'h900, 4'd3);
    run_done(200, "lenerr2");
    chk("len_err_sticky", o_len_err, 128'd1);

    // Async reset in the middle of a write burst.
    both(1'b1, 0, 28'hA00, 4'd15);
    n = 0;
    while ((ip_w_beat < 5) && (n < 300)) begin
      step();
      n++;
    end
    chk("rst_reached_beat5", 128'(ip_w_beat), 128'd5);
    #1 ddr_rst = 1'b1;
    #1 chk_outs_zero("async_rst");
    clear_model();
    idle_inputs();
    repeat (2) @(posedge core_clk);
    #1 ddr_rst = 1'b0;
    #1 chk("post_rst_len_err", o_len_err, 128'd0);
    add_cmd(1'b0, 1, 28'hB00, 4'd1);
    add_cmd(1'b0, 0, 28'hC00, 4'd1);
    exp_cmd(1'b0, 0, 28'hC00, 4'd1);
    exp_cmd(1'b0, 1, 28'hB00, 4'd1);
    run_done(200, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
